// File: rtl/sync_ram_clear.sv
// Single-port synchronous RAM; an internal sequencer writes the preload pattern after reset and on each clear.
// Reads and writes take 1 cycle. No backpressure: while busy is high, we and clear are ignored and q holds.
module sync_ram_clear #(
  parameter int               WIDTH      = 4,
  parameter int               ADDR_W     = 4,
  parameter logic [WIDTH-1:0] INIT_FIRST = WIDTH'(1),
  parameter logic [WIDTH-1:0] INIT_FILL  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              we,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  q,
  output logic              busy,
  output logic              done
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [WIDTH-1:0]  r_ram [DEPTH];
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  w_init;
  logic              w_wr;

  // clear outranks a same-cycle user write
  assign w_wr   = (r_state == S_IDLE) && we && !clear;
  assign w_init = (r_ptr == '0) ? INIT_FIRST : INIT_FILL;

  assign busy = (r_state == S_CLEAR);
  assign done = (r_state == S_CLEAR) && (r_ptr == LAST);
  assign q    = r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_CLEAR: begin
        w_ptr_nxt = r_ptr + ADDR_W'(1);
        if (r_ptr == LAST) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clear) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  // No reset on the array so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_ram[r_ptr] <= w_init;
    end else if (w_wr) begin
      r_ram[addr] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else if (r_state == S_IDLE) begin
      r_q <= w_wr ? data : r_ram[addr];
    end
  end

endmodule

// File: tb/tb_sync_ram_clear.sv
// Bench for sync_ram_clear: default instance plus an 8-bit / 32-deep instance, checked against an array model.
module tb_sync_ram_clear;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, clear, we, busy, done;
  logic [3:0] data, addr, q;

  logic       b_reset_n, b_clear, b_we, b_busy, b_done;
  logic [7:0] b_data, b_q;
  logic [4:0] b_addr;

  int checks   = 0;
  int failures = 0;
  logic [3:0] model [16];

  sync_ram_clear u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .we(we), .data(data),
    .addr(addr), .q(q), .busy(busy), .done(done)
  );

  sync_ram_clear #(.WIDTH(8), .ADDR_W(5), .INIT_FIRST(8'h3C), .INIT_FILL(8'h55)) u_dut8 (
    .clk(clk), .reset_n(b_reset_n), .clear(b_clear), .we(b_we), .data(b_data),
    .addr(b_addr), .q(b_q), .busy(b_busy), .done(b_done)
  );

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model[i] = (i == 0) ? 4'd1 : 4'd0;
  endtask

  task automatic test_reset();
    logic exp_done;
    reset_n = 1'b0; clear = 1'b0; we = 1'b0; data = '0; addr = '0;
    repeat (2) @(negedge clk);
    checks++; if (q !== 4'd0)   begin failures++; $display("FAIL reset_q got=%h exp=0", q); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    reset_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      exp_done = (c == 16) ? 1'b1 : 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL init_busy cyc=%0d got=%b exp=1", c, busy); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL init_done cyc=%0d got=%b exp=%b", c, done, exp_done); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL init_busy_end got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL init_done_end got=%b exp=0", done); end
    model_clear();
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      @(negedge clk);
      checks++; if (q !== model[a]) begin failures++; $display("FAIL init_read addr=%0d got=%h exp=%h", a, q, model[a]); end
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; addr = 4'd5; data = 4'hA;
    @(negedge clk);
    model[5] = 4'hA;
    we = 1'b0;
    @(negedge clk);
    checks++; if (q !== 4'hA) begin failures++; $display("FAIL write_read got=%h exp=a", q); end
    addr = 4'd6;
    @(negedge clk);
    checks++; if (q !== 4'h0) begin failures++; $display("FAIL read_other got=%h exp=0", q); end
  endtask

  task automatic test_write_first();
    we = 1'b1; addr = 4'd3; data = 4'h7;
    @(negedge clk);
    model[3] = 4'h7;
    checks++; if (q !== 4'h7) begin failures++; $display("FAIL write_first got=%h exp=7", q); end
    we = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] exp;
    for (int n = 0; n < 200; n++) begin
      we   = 1'($urandom);
      addr = 4'($urandom);
      data = 4'($urandom);
      exp  = we ? data : model[addr];
      if (we) model[addr] = data;
      @(negedge clk);
      checks++; if (q !== exp) begin failures++; $display("FAIL random n=%0d addr=%0d got=%h exp=%h", n, addr, q, exp); end
    end
    we = 1'b0;
  endtask

  task automatic test_clear_during_op();
    logic [3:0] qhold;
    int ndone;
    for (int a = 0; a < 16; a++) begin
      we = 1'b1; addr = 4'(a); data = 4'hF;
      @(negedge clk);
      model[a] = 4'hF;
    end
    clear = 1'b1; we = 1'b1; addr = 4'd2; data = 4'h9;
    @(negedge clk);
    clear = 1'b0;
    qhold = q;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clr_busy i=%0d got=%b exp=1", i, busy); end
      checks++; if (q !== qhold) begin failures++; $display("FAIL clr_q_hold i=%0d got=%h exp=%h", i, q, qhold); end
      if (done === 1'b1) ndone++;
      we = 1'($urandom); addr = 4'($urandom); data = 4'($urandom);
      @(negedge clk);
    end
    we = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy_end got=%b exp=0", busy); end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL clr_done_count got=%0d exp=1", ndone); end
    model_clear();
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      @(negedge clk);
      checks++; if (q !== model[a]) begin failures++; $display("FAIL clr_read addr=%0d got=%h exp=%h", a, q, model[a]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic exp_done;
    we = 1'b0; addr = 4'd0;
    @(negedge clk);
    checks++; if (q !== 4'd1) begin failures++; $display("FAIL rmc_pre_read got=%h exp=1", q); end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (q !== 4'd0)    begin failures++; $display("FAIL rmc_q got=%h exp=0", q); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmc_busy got=%b exp=1", busy); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      exp_done = (c == 16) ? 1'b1 : 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmc_busy cyc=%0d got=%b exp=1", c, busy); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL rmc_done cyc=%0d got=%b exp=%b", c, done, exp_done); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmc_busy_end got=%b exp=0", busy); end
    model_clear();
    addr = 4'd0;
    @(negedge clk);
    checks++; if (q !== 4'd1) begin failures++; $display("FAIL rmc_read0 got=%h exp=1", q); end
    addr = 4'd9;
    @(negedge clk);
    checks++; if (q !== 4'd0) begin failures++; $display("FAIL rmc_read9 got=%h exp=0", q); end
  endtask

  task automatic test_param_sweep();
    logic exp_done;
    b_clear = 1'b0; b_we = 1'b0; b_data = '0; b_addr = '0;
    @(negedge clk);
    b_reset_n = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      exp_done = (c == 32) ? 1'b1 : 1'b0;
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL p8_busy cyc=%0d got=%b exp=1", c, b_busy); end
      checks++; if (b_done !== exp_done) begin failures++; $display("FAIL p8_done cyc=%0d got=%b exp=%b", c, b_done, exp_done); end
      @(negedge clk);
    end
    checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL p8_busy_end got=%b exp=0", b_busy); end
    b_addr = 5'd0;
    @(negedge clk);
    checks++; if (b_q !== 8'h3C) begin failures++; $display("FAIL p8_read0 got=%h exp=3c", b_q); end
    b_addr = 5'd31;
    @(negedge clk);
    checks++; if (b_q !== 8'h55) begin failures++; $display("FAIL p8_read31 got=%h exp=55", b_q); end
    b_we = 1'b1; b_data = 8'hFF;
    @(negedge clk);
    b_we = 1'b0; b_data = 8'h00;
    @(negedge clk);
    checks++; if (b_q !== 8'hFF) begin failures++; $display("FAIL p8_wr31 got=%h exp=ff", b_q); end
  endtask

  initial begin
    b_reset_n = 1'b0; b_clear = 1'b0; b_we = 1'b0; b_data = '0; b_addr = '0;
    test_reset();
    test_write_read();
    test_write_first();
    test_random();
    test_clear_during_op();
    test_reset_mid_clear();
    test_param_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
